// File: rtl/spi_arb_pkg.sv
// Shared types and register map for the SPI transfer arbiter.
package spi_arb_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StFlush1,
        StFlush2,
        StWr1,
        StWr2,
        StWaitRx,
        StRd1,
        StRd2,
        StClr1,
        StClr2,
        StDone
    } arb_state_e;

    localparam logic [2:0] SPI_ADDR_RXDATA = 3'd0;
    localparam logic [2:0] SPI_ADDR_TXDATA = 3'd1;
    localparam logic [2:0] SPI_ADDR_STATUS = 3'd2;

endpackage

// File: rtl/spi_arb_pick.sv
// Combinational winner select. Fixed lowest-index priority by default;
// define SPI_ARB_RR_EN for round-robin starting after last_grant.
module spi_arb_pick #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [NREQ-1:0]  grant,
    output logic             valid
);

    assign valid = |req;

`ifdef SPI_ARB_RR_EN
    logic [IDX_W-1:0] start;
    logic [NREQ-1:0]  rot_req;
    logic [NREQ-1:0]  rot_gnt;

    // Rotate so the search origin sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        start   = (32'(last_grant) >= NREQ - 1) ? '0 : last_grant + IDX_W'(1);
        rot_req = NREQ'({req, req} >> start);
        rot_gnt = rot_req & (~rot_req + NREQ'(1));
        grant   = NREQ'({rot_gnt, rot_gnt} >> (NREQ - 32'(start)));
    end
`else
    logic unused_last_grant;

    assign unused_last_grant = ^last_grant;
    assign grant             = req & (~req + NREQ'(1));
`endif

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Serialises requester transfers onto the SPI core register port and returns rx words.
// Arbitration policy is selected by SPI_ARB_RR_EN (see spi_arb_pick).
module spi_xfer_arbiter #(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned DATA_W    = 20,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        ack,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   spi_select,
    output logic [2:0]             mem_addr,
    output logic                   write_n,
    output logic                   read_n,
    output logic [31:0]            data_from_cpu,
    input  logic [31:0]            data_to_cpu,
    input  logic                   readyfordata,
    input  logic                   dataavailable
);

    import spi_arb_pkg::*;

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic                 err_q, err_d;

    logic [NREQ-1:0]      grant;
    logic                 grant_valid;
    logic [IDX_W-1:0]     grant_idx;
    logic [DATA_W-1:0]    grant_wdata;
    logic                 unused_rx_bits;

    assign unused_rx_bits = ^data_to_cpu;
    assign rsp_rdata      = rdata_q;

    spi_arb_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (req),
        .last_grant (last_q),
        .grant      (grant),
        .valid      (grant_valid)
    );

    always_comb begin
        grant_idx   = '0;
        grant_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx   = IDX_W'(i);
                grant_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        last_d        = last_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        tmo_d         = tmo_q;
        err_d         = err_q;
        spi_select    = 1'b0;
        write_n       = 1'b1;
        read_n        = 1'b1;
        mem_addr      = SPI_ADDR_RXDATA;
        data_from_cpu = '0;
        ack           = '0;
        rsp_err       = 1'b0;
        busy          = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                // A leftover rx word must be drained before it can be mistaken for a reply.
                if (dataavailable) begin
                    state_d = StFlush1;
                end else if (grant_valid) begin
                    idx_d   = grant_idx;
                    last_d  = grant_idx;
                    wdata_d = grant_wdata;
                    state_d = StWr1;
                end
            end
            StFlush1, StFlush2: begin
                spi_select = 1'b1;
                read_n     = 1'b0;
                state_d    = (state_q == StFlush1) ? StFlush2 : StIdle;
            end
            StWr1, StWr2: begin
                if (state_q == StWr2 || readyfordata) begin
                    spi_select    = 1'b1;
                    write_n       = 1'b0;
                    mem_addr      = SPI_ADDR_TXDATA;
                    data_from_cpu = 32'(wdata_q);
                    state_d       = (state_q == StWr1) ? StWr2 : StWaitRx;
                end
            end
            StWaitRx: begin
                tmo_d = tmo_q + TIMEOUT_W'(1);
                if (dataavailable) begin
                    state_d = StRd1;
                end else if (&tmo_d) begin
                    err_d   = 1'b1;
                    state_d = StClr1;
                end
            end
            StRd1, StRd2: begin
                spi_select = 1'b1;
                read_n     = 1'b0;
                if (state_q == StRd2) begin
                    rdata_d = data_to_cpu[DATA_W-1:0];
                    state_d = StDone;
                end else begin
                    state_d = StRd2;
                end
            end
            StClr1, StClr2: begin
                spi_select = 1'b1;
                write_n    = 1'b0;
                mem_addr   = SPI_ADDR_STATUS;
                state_d    = (state_q == StClr1) ? StClr2 : StDone;
            end
            StDone: begin
                ack     = NREQ'(1) << idx_q;
                rsp_err = err_q;
                tmo_d   = '0;
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            last_q  <= IDX_W'(NREQ - 1);
            wdata_q <= '0;
            rdata_q <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Self-checking bench: scripted SPI core plus a cycle-level schedule model of each transfer.
module tb_spi_xfer_arbiter;

    localparam int unsigned NREQ      = 3;
    localparam int unsigned DATA_W    = 20;
    localparam int unsigned TIMEOUT_W = 4;
    localparam int          NR        = int'(NREQ);
    localparam int          TMO_CYC   = (1 << TIMEOUT_W) - 1;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        ack;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic                   busy;
    logic                   spi_select;
    logic [2:0]             mem_addr;
    logic                   write_n;
    logic                   read_n;
    logic [31:0]            data_from_cpu;
    logic [31:0]            data_to_cpu;
    logic                   readyfordata;
    logic                   dataavailable;

    spi_xfer_arbiter #(
        .NREQ      (NREQ),
        .DATA_W    (DATA_W),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .req_wdata     (req_wdata),
        .ack           (ack),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .busy          (busy),
        .spi_select    (spi_select),
        .mem_addr      (mem_addr),
        .write_n       (write_n),
        .read_n        (read_n),
        .data_from_cpu (data_from_cpu),
        .data_to_cpu   (data_to_cpu),
        .readyfordata  (readyfordata),
        .dataavailable (dataavailable)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected outputs for the current cycle.
    logic              e_chk = 1'b0;
    logic              e_busy, e_sel, e_wn, e_rn, e_err;
    logic [2:0]        e_addr;
    logic [31:0]       e_wdata;
    logic [NREQ-1:0]   e_ack;
    logic [DATA_W-1:0] e_rdata;

    // Requester and response model.
    logic [NREQ-1:0]   pend;
    logic [DATA_W-1:0] wd [NREQ];
    logic [DATA_W-1:0] mdl_rdata;
    int                mdl_last;

    int                obs_idx[$];
    logic [DATA_W-1:0] obs_rdata[$];
    logic              obs_err[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int ai;
        if (e_chk) begin
            chk("busy", 32'(busy), 32'(e_busy));
            chk("spi_select", 32'(spi_select), 32'(e_sel));
            chk("write_n", 32'(write_n), 32'(e_wn));
            chk("read_n", 32'(read_n), 32'(e_rn));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            if (!e_wn) chk("data_from_cpu", data_from_cpu, e_wdata);
            chk("ack", 32'(ack), 32'(e_ack));
            chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
            if (e_ack != '0) chk("rsp_err", 32'(rsp_err), 32'(e_err));
        end
        if (ack != '0) begin
            ai = 0;
            for (int i = 0; i < NR; i++) if (ack[i]) ai = i;
            obs_idx.push_back(ai);
            obs_rdata.push_back(rsp_rdata);
            obs_err.push_back(rsp_err);
        end
    end

    function automatic int pick(input logic [NREQ-1:0] r, input int last);
`ifdef SPI_ARB_RR_EN
        for (int k = 1; k <= NR; k++) if (r[(last + k) % NR]) return (last + k) % NR;
`else
        for (int i = 0; i < NR; i++) if (r[i]) return i;
`endif
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        req = pend;
        for (int i = 0; i < NR; i++) req_wdata[i*DATA_W +: DATA_W] = wd[i];
    endtask

    task automatic arrive(input int pct);
        for (int i = 0; i < NR; i++) begin
            if (!pend[i] && int'($urandom_range(99)) < pct) begin
                pend[i] = 1'b1;
                wd[i]   = DATA_W'($urandom);
            end
        end
    endtask

    task automatic exp_bus(input logic b, input logic sel, input logic wn, input logic rn,
                           input logic [2:0] a, input logic [31:0] d);
        e_busy  = b;
        e_sel   = sel;
        e_wn    = wn;
        e_rn    = rn;
        e_addr  = a;
        e_wdata = d;
        e_ack   = '0;
        e_rdata = mdl_rdata;
    endtask

    task automatic exp_quiet(input logic b);
        exp_bus(b, 1'b0, 1'b1, 1'b1, 3'd0, 32'd0);
    endtask

    // Reset pulse starting mid-cycle; returns with reset released and the DUT idle.
    task automatic do_reset();
        pend = '0;
        drive();
        dataavailable = 1'b0;
        #2 reset_n = 1'b0;
        mdl_rdata = '0;
        mdl_last  = NR - 1;
        exp_quiet(1'b0);
        tick();
        exp_quiet(1'b0);
        tick();
        reset_n = 1'b1;
    endtask

    // IDLE cycle with a stale rx flag followed by the two-cycle drain read.
    task automatic flush(input int arr);
        arrive(arr);
        drive();
        dataavailable = 1'b1;
        exp_quiet(1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            arrive(arr);
            drive();
            exp_bus(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 32'd0);
            tick();
        end
        dataavailable = 1'b0;
    endtask

    // One transfer starting from an IDLE cycle with at least one pending request.
    task automatic xfer(input int stall, input int lat, input bit tmo, input int rst_at,
                        input int arr);
        int                w;
        logic [DATA_W-1:0] rx;
        arrive(arr);
        drive();
        dataavailable = 1'b0;
        readyfordata  = 1'($urandom);
        data_to_cpu   = $urandom;
        w             = pick(pend, mdl_last);
        mdl_last      = w;
        exp_quiet(1'b0);
        tick();
        for (int s = 0; s < stall; s++) begin
            arrive(arr); drive();
            readyfordata = 1'b0;
            exp_quiet(1'b1);
            tick();
        end
        arrive(arr); drive();
        readyfordata = 1'b1;
        exp_bus(1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 32'(wd[w]));
        tick();
        arrive(arr); drive();
        readyfordata = 1'($urandom);
        exp_bus(1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 32'(wd[w]));
        tick();
        if (!tmo) begin
            for (int k = 0; k < lat; k++) begin
                arrive(arr); drive();
                if (k == rst_at) begin
                    do_reset();
                    return;
                end
                exp_quiet(1'b1);
                tick();
            end
            arrive(arr); drive();
            dataavailable = 1'b1;
            exp_quiet(1'b1);
            tick();
            rx = wd[w];
            data_to_cpu = $urandom;
            data_to_cpu[DATA_W-1:0] = rx;
            for (int k = 0; k < 2; k++) begin
                arrive(arr); drive();
                exp_bus(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 32'd0);
                tick();
            end
            mdl_rdata     = rx;
            dataavailable = 1'b0;
            data_to_cpu   = $urandom;
        end else begin
            for (int k = 0; k < TMO_CYC; k++) begin
                arrive(arr); drive();
                exp_quiet(1'b1);
                tick();
            end
            for (int k = 0; k < 2; k++) begin
                arrive(arr); drive();
                exp_bus(1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 32'd0);
                tick();
            end
        end
        arrive(arr); drive();
        exp_quiet(1'b1);
        e_ack = NREQ'(1) << w;
        e_err = tmo;
        tick();
        pend[w] = 1'b0;
        e_ack   = '0;
    endtask

    task automatic lit(input string name, input int exp_idx, input logic [DATA_W-1:0] exp_rd,
                       input logic exp_err);
        if (obs_idx.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no ack seen, want ack index %0d", name, exp_idx);
        end else begin
            chk({name, "_idx"}, 32'(obs_idx.pop_front()), 32'(exp_idx));
            chk({name, "_rdata"}, 32'(obs_rdata.pop_front()), 32'(exp_rd));
            chk({name, "_err"}, 32'(obs_err.pop_front()), 32'(exp_err));
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        req           = '0;
        req_wdata     = '0;
        readyfordata  = 1'b0;
        dataavailable = 1'b0;
        data_to_cpu   = '0;
        pend          = '0;
        for (int i = 0; i < NR; i++) wd[i] = '0;
        mdl_rdata = '0;
        mdl_last  = NR - 1;
        e_err     = 1'b0;
        exp_quiet(1'b0);
        #1 e_chk = 1'b1;
        tick();
        tick();

        // Stale rx flag at reset release with req[1] pending.
        pend  = NREQ'(2);
        wd[1] = 20'h3C3C3;
        reset_n = 1'b1;
        flush(0);
        xfer(0, 2, 1'b0, -1, 0);
        lit("stale", 1, 20'h3C3C3, 1'b0);

        // Single transfer, loopback.
        pend  = NREQ'(1);
        wd[0] = 20'hA5A5A;
        xfer(0, 3, 1'b0, -1, 0);
        lit("single", 0, 20'hA5A5A, 1'b0);

        // Contention right after reset: 0 then 1 under either policy.
        do_reset();
        pend  = NREQ'(3);
        wd[0] = 20'h00001;
        wd[1] = 20'h00002;
        xfer(0, 1, 1'b0, -1, 0);
        xfer(0, 4, 1'b0, -1, 0);
        lit("cont_first", 0, 20'h00001, 1'b0);
        lit("cont_second", 1, 20'h00002, 1'b0);

        // Timeout keeps the previous rx word.
        pend  = NREQ'(4);
        wd[2] = 20'h55555;
        xfer(0, 0, 1'b1, -1, 0);
        lit("timeout", 2, 20'h00002, 1'b1);

        // TRDY stall for 5 cycles.
        pend  = NREQ'(1);
        wd[0] = 20'h12345;
        xfer(5, 1, 1'b0, -1, 0);
        lit("stall", 0, 20'h12345, 1'b0);

        // Reset mid-WAIT_RX, then a normal transfer.
        pend  = NREQ'(2);
        wd[1] = 20'hFEDCB;
        xfer(0, 6, 1'b0, 3, 0);
        chk("ack_after_reset", 32'(obs_idx.size()), 32'd0);
        pend  = NREQ'(2);
        wd[1] = 20'h0BEEF;
        xfer(0, 2, 1'b0, -1, 0);
        lit("post_reset", 1, 20'h0BEEF, 1'b0);

        // Randomised traffic.
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(19) == 0) begin
                flush(10);
            end else begin
                arrive(30);
                if (pend == '0) begin
                    drive();
                    exp_quiet(1'b0);
                    tick();
                end else begin
                    xfer(int'($urandom_range(3)), int'($urandom_range(TMO_CYC - 2)),
                         ($urandom_range(9) == 0), -1, 10);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
